// File: rtl/tnoc_output_port_scheduler.sv
// tnoc_output_port_scheduler
//   Per-output-port scheduler for the 5x5 router crossbar. The scheduler shares
//   one output port between the input blocks and their virtual channels. It
//   allocates the port per packet: the winner keeps the port until its tail
//   flit is transferred. It also tracks downstream credits per VC.
//
//   Arbitration has two round-robin levels. The first level picks a VC, starting
//   at the VC pointer. The second level picks a requester inside that VC,
//   starting at that VC's requester pointer. A VC is only eligible while it has
//   at least one credit.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   i_request           : bit c*REQUESTERS+r set -> requester r has a head on VC c
//   i_tail              : presented flit of requester r is a tail
//   i_transfer          : one flit moved through the port this cycle
//   i_credit_return     : downstream freed one slot of VC c
//   o_grant / o_grant_vc: one-hot winner / its VC (zero when idle)
//   o_busy              : a packet holds the port
//   o_credit_available  : credit[c] > 0
//   o_error             : (TNOC_SCHEDULER_ERROR_STATUS_EN only)
//                         [0] sticky underflow, [1] sticky overflow
module tnoc_output_port_scheduler #(
    parameter int REQUESTERS = 5,
    parameter int CHANNELS   = 2,
    parameter int CREDITS    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*REQUESTERS-1:0] i_request,
    input  logic [REQUESTERS-1:0]          i_tail,
    input  logic                           i_transfer,
    input  logic [CHANNELS-1:0]            i_credit_return,
    output logic [REQUESTERS-1:0]          o_grant,
    output logic [CHANNELS-1:0]            o_grant_vc,
    output logic                           o_busy,
    output logic [CHANNELS-1:0]            o_credit_available
`ifdef TNOC_SCHEDULER_ERROR_STATUS_EN
    ,
    output logic [1:0]                     o_error
`endif
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int RW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int VW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                             state_q, state_d;
    logic [REQUESTERS-1:0]              grant_q, grant_d;
    logic [CHANNELS-1:0]                grant_vc_q, grant_vc_d;
    logic [RW-1:0]                      win_q, win_d;       // index of granted requester
    logic [VW-1:0]                      vc_q, vc_d;         // index of granted VC
    logic [VW-1:0]                      vc_ptr_q, vc_ptr_d;
    logic [CHANNELS-1:0][RW-1:0]        req_ptr_q, req_ptr_d;
    logic [CHANNELS-1:0][CW-1:0]        credit_q, credit_d;
    logic [1:0]                         err_q, err_d;

    logic tail_xfer;
    logic found_vc, found_r;
    int   pick_vc, pick_r, idx;
    logic dec, inc;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_vc_d = grant_vc_q;
        win_d      = win_q;
        vc_d       = vc_q;
        vc_ptr_d   = vc_ptr_q;
        req_ptr_d  = req_ptr_q;
        credit_d   = credit_q;
        err_d      = err_q;
        found_vc   = 1'b0;
        found_r    = 1'b0;
        pick_vc    = 0;
        pick_r     = 0;
        idx        = 0;
        dec        = 1'b0;
        inc        = 1'b0;

        tail_xfer = (state_q == LOCKED) && i_transfer && i_tail[win_q];

        // A transfer while idle is not charged to any VC.
        if (state_q == IDLE && i_transfer) err_d[0] = 1'b1;

        // Credit update: simultaneous take and return cancel out, and both ends saturate.
        for (int c = 0; c < CHANNELS; c++) begin
            dec = (state_q == LOCKED) && i_transfer && (vc_q == VW'(c));
            inc = i_credit_return[c];
            if (dec && !inc) begin
                if (credit_q[c] == '0) err_d[0] = 1'b1;
                else                   credit_d[c] = credit_q[c] - 1'b1;
            end else if (inc && !dec) begin
                if (credit_q[c] == CW'(CREDITS)) err_d[1] = 1'b1;
                else                             credit_d[c] = credit_q[c] + 1'b1;
            end
        end

        // The tail moves both pointers past the winner before re-arbitration.
        if (tail_xfer) begin
            req_ptr_d[vc_q] = (win_q == RW'(REQUESTERS - 1)) ? '0 : win_q + 1'b1;
            vc_ptr_d        = (vc_q == VW'(CHANNELS - 1))   ? '0 : vc_q + 1'b1;
        end

        // Eligibility uses the post-transfer credits, so a VC whose last credit
        // was just consumed is skipped.
        for (int i = 0; i < CHANNELS; i++) begin
            idx = (int'(vc_ptr_d) + i) % CHANNELS;
            if (!found_vc && (|i_request[idx*REQUESTERS +: REQUESTERS]) && credit_d[idx] != '0) begin
                found_vc = 1'b1;
                pick_vc  = idx;
            end
        end
        for (int j = 0; j < REQUESTERS; j++) begin
            idx = (int'(req_ptr_d[pick_vc]) + j) % REQUESTERS;
            if (!found_r && i_request[pick_vc*REQUESTERS + idx]) begin
                found_r = 1'b1;
                pick_r  = idx;
            end
        end

        if (state_q == IDLE || tail_xfer) begin
            grant_d    = '0;
            grant_vc_d = '0;
            if (found_vc) begin
                state_d             = LOCKED;
                grant_d[pick_r]     = 1'b1;
                grant_vc_d[pick_vc] = 1'b1;
                win_d               = RW'(pick_r);
                vc_d                = VW'(pick_vc);
            end else begin
                state_d = IDLE;
                win_d   = '0;
                vc_d    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_vc_q <= '0;
            win_q      <= '0;
            vc_q       <= '0;
            vc_ptr_q   <= '0;
            req_ptr_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) credit_q[c] <= CW'(CREDITS);
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_vc_q <= grant_vc_d;
            win_q      <= win_d;
            vc_q       <= vc_d;
            vc_ptr_q   <= vc_ptr_d;
            req_ptr_q  <= req_ptr_d;
            credit_q   <= credit_d;
            err_q      <= err_d;
        end
    end

    assign o_grant    = grant_q;
    assign o_grant_vc = grant_vc_q;
    assign o_busy     = (state_q == LOCKED);
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) o_credit_available[c] = (credit_q[c] != '0);
    end

`ifdef TNOC_SCHEDULER_ERROR_STATUS_EN
    assign o_error = err_q;
`else
    logic unused_err;
    assign unused_err = ^err_q;
`endif

endmodule

// File: tb/tb_tnoc_output_port_scheduler.sv
module tb_tnoc_output_port_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] i_request;
    logic [4:0] i_tail;
    logic       i_transfer;
    logic [1:0] i_credit_return;
    logic [4:0] o_grant;
    logic [1:0] o_grant_vc;
    logic       o_busy;
    logic [1:0] o_credit_available;
`ifdef TNOC_SCHEDULER_ERROR_STATUS_EN
    logic [1:0] o_error;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tnoc_output_port_scheduler dut (
        .clk                (clk),
        .rst                (rst),
        .i_request          (i_request),
        .i_tail             (i_tail),
        .i_transfer         (i_transfer),
        .i_credit_return    (i_credit_return),
        .o_grant            (o_grant),
        .o_grant_vc         (o_grant_vc),
        .o_busy             (o_busy),
        .o_credit_available (o_credit_available)
`ifdef TNOC_SCHEDULER_ERROR_STATUS_EN
        ,
        .o_error            (o_error)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_request = '0; i_tail = '0; i_transfer = 0; i_credit_return = '0;
        rst = 1; step(); rst = 0;
    endtask

    initial begin
        // Reset state and basic one-cycle grant latency.
        do_reset();
        chk("rst_grant", o_grant, 5'b00000);
        chk("rst_vc", o_grant_vc, 2'b00);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_avail", o_credit_available, 2'b11);
        i_request = 10'b00000_00100;
        step();
        chk("t1_grant", o_grant, 5'b00100);
        chk("t1_vc", o_grant_vc, 2'b01);
        chk("t1_busy", o_busy, 1'b1);

        // Multi-flit packet followed by a back-to-back handoff to r3.
        do_reset();
        i_request = 10'b00000_01001;
        step();
        chk("t2_first", o_grant, 5'b00001);
        i_transfer = 1; step(); step();
        chk("t2_hold", o_grant, 5'b00001);
        i_tail = 5'b00001; step();
        chk("t2_next", o_grant, 5'b01000);
        chk("t2_next_busy", o_busy, 1'b1);
        i_request = '0; i_tail = 5'b01000; step();
        chk("t2_idle", o_grant, 5'b00000);
        chk("t2_idle_busy", o_busy, 1'b0);
        chk("t2_credit0", o_credit_available, 2'b10);
        i_transfer = 0; i_tail = '0;

        // Single-flit packets alternate between the VCs.
        do_reset();
        i_request = 10'b00100_00010;
        step();
        chk("t3_g0", {o_grant_vc, o_grant}, {2'b01, 5'b00010});
        i_transfer = 1; i_tail = 5'b11111; step();
        chk("t3_g1", {o_grant_vc, o_grant}, {2'b10, 5'b00100});
        step();
        chk("t3_g2", {o_grant_vc, o_grant}, {2'b01, 5'b00010});
        i_transfer = 0; i_tail = '0;

        // Credit exhaustion holds the lock until credit is returned.
        do_reset();
        i_request = 10'b00000_10000;
        step();
        chk("t4_grant", o_grant, 5'b10000);
        i_request = '0; i_transfer = 1;
        for (int k = 0; k < 4; k++) step();
        chk("t4_empty", o_credit_available, 2'b10);
        chk("t4_held", o_grant, 5'b10000);
        chk("t4_busy", o_busy, 1'b1);
        i_transfer = 0; i_credit_return = 2'b01; step();
        chk("t4_ret", o_credit_available, 2'b11);
        i_credit_return = '0; i_transfer = 1; step();
        chk("t4_held2", o_grant, 5'b10000);
        i_credit_return = 2'b01; i_tail = 5'b10000; step();
        chk("t4_done", o_busy, 1'b0);
        chk("t4_done_cr", o_credit_available, 2'b10);
        i_transfer = 0; i_credit_return = '0; i_tail = '0;

        // Same-cycle transfer and return, and a return at full credit.
        do_reset();
        i_request = 10'b00001_00000;
        step();
        chk("t5_grant", {o_grant_vc, o_grant}, {2'b10, 5'b00001});
        i_request = '0; i_transfer = 1; step(); step();
        i_credit_return = 2'b10; step();
        i_credit_return = '0; step();
        chk("t5_one", o_credit_available, 2'b11);
        step();
        chk("t5_zero", o_credit_available, 2'b01);
        i_transfer = 0; i_credit_return = 2'b01; step();
        i_credit_return = '0;
        chk("t5_sat", o_credit_available, 2'b01);
`ifdef TNOC_SCHEDULER_ERROR_STATUS_EN
        chk("t5_err", o_error, 2'b10);
`endif

        // Reset mid-packet drops the lock and restores credits.
        do_reset();
        i_request = 10'b00000_01000;
        step();
        chk("t6_grant", o_grant, 5'b01000);
        i_transfer = 1; step(); step();
        rst = 1; step(); rst = 0; i_transfer = 0;
        chk("t6_rst_grant", o_grant, 5'b00000);
        chk("t6_rst_busy", o_busy, 1'b0);
        chk("t6_rst_avail", o_credit_available, 2'b11);
        step();
        chk("t6_regrant", o_grant, 5'b01000);
        i_request = '0; i_transfer = 1;
        for (int k = 0; k < 3; k++) step();
        chk("t6_three", o_credit_available, 2'b11);
        step();
        chk("t6_four", o_credit_available, 2'b10);
        i_transfer = 0;

        // Transfers while idle leave credits untouched.
        do_reset();
        i_transfer = 1; step(); step(); step(); step();
        chk("t7_idle_xfer", o_credit_available, 2'b11);
        chk("t7_idle_busy", o_busy, 1'b0);
`ifdef TNOC_SCHEDULER_ERROR_STATUS_EN
        chk("t7_err", o_error, 2'b01);
`endif
        i_transfer = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
